dot_product_pipe: RTL and testbench

//  Pipelined, streaming signed dot-product engine; successor to the combinational dot-product blocks.
//  - Each accepted beat multiplies DEPTH signed element pairs and sums the products in an adder tree.
//  - Beat sums accumulate across a vector that spans one or more beats; in_last closes the vector.
//  - Sits between the activation/weight read buffers and the post-processing (bias/activation) stage.

---
 rtl/dp_pkg.sv | 18 +
 rtl/dot_product_pipe_if.sv | 31 +++
 rtl/dp_adder_tree.sv | 33 +++
 rtl/dot_product_pipe.sv | 188 ++++++++++++++++++
 tb/tb_dot_product_pipe.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// Shared widths, accumulator type and clamp limits for the dot-product pipeline.
// Pure declarations: no latency, no flow control.
// Consumers import dp_pkg::* and size their adders with sum_w().
package dp_pkg;

    localparam int ACC_W_DEF = 32;

    typedef logic signed [ACC_W_DEF-1:0] acc_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    // Width of one beat's adder-tree sum: product width plus tree growth.
    function automatic int sum_w(input int dw, input int depth);
        return 2 * dw + $clog2(depth);
    endfunction

endpackage

// File: rtl/dot_product_pipe_if.sv
// Beat input stream and result output stream of the dot-product pipeline.
// Wires only: no latency of its own.
// Valid/ready on both sides; slave is the pipeline, master is its driver.
interface dot_product_pipe_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic [DEPTH-1:0][DW-1:0]      in_a;
    logic [DEPTH-1:0][DW-1:0]      in_b;
    logic                          in_last;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [ACC_W-1:0]       out_res;
    logic [CNT_W-1:0]              out_len;
    logic                          out_sat;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_res, out_len, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_res, out_len, out_sat
    );

endinterface

// File: rtl/dp_adder_tree.sv
// Sums DEPTH signed products in a balanced tree, zero-padded to the next power of two.
// Combinational: zero cycles.
// No flow control; the caller registers input and output.
module dp_adder_tree
    import dp_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic signed [2*DW-1:0]              prod [DEPTH],
    output logic signed [sum_w(DW, DEPTH)-1:0]  sum
);

    localparam int SUM_W = sum_w(DW, DEPTH);
    localparam int P2    = 1 << $clog2(DEPTH);

    // Heap layout: leaves at P2..2*P2-1, node i sums children 2i and 2i+1, root at 1.
    logic signed [SUM_W-1:0] node [1:2*P2-1];

    always_comb begin
        for (int i = 1; i < 2 * P2; i++) begin
            node[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            node[P2 + i] = SUM_W'(prod[i]);
        end
        for (int i = P2 - 1; i >= 1; i--) begin
            node[i] = node[2 * i] + node[2 * i + 1];
        end
        sum = node[1];
    end

endmodule

// File: rtl/dot_product_pipe.sv
// Streaming signed dot product: multiply, adder tree, accumulate across beats up to in_last.
// Latency 3 cycles from last-beat accept to out_valid; one beat per clock.
// Global stall: held result (out_valid && !out_ready) freezes every stage. DP_SAT_EN selects clamped accumulation.
module dot_product_pipe
    import dp_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    dot_product_pipe_if.slave bus
);

    localparam int SUM_W = sum_w(DW, DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef logic signed [2*DW-1:0]  prod_t;
    typedef logic signed [ACC_W-1:0] accw_t;

    logic                   en;

    logic                   s1_vld_q, s1_vld_d;
    logic                   s1_last_q, s1_last_d;
    prod_t                  s1_prod_q [DEPTH];
    prod_t                  s1_prod_d [DEPTH];

    logic                   s2_vld_q, s2_vld_d;
    logic                   s2_last_q, s2_last_d;
    logic signed [SUM_W-1:0] s2_sum_q, s2_sum_d;
    logic signed [SUM_W-1:0] tree_sum;

    accw_t                  acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    accw_t                  sum_ext;
    accw_t                  acc_next;

    logic                   out_vld_q, out_vld_d;
    accw_t                  out_res_q, out_res_d;
    logic [CNT_W-1:0]       out_len_q, out_len_d;

    dp_adder_tree #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_tree (
        .prod (s1_prod_q),
        .sum  (tree_sum)
    );

    assign sum_ext = ACC_W'(s2_sum_q);
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

`ifdef DP_SAT_EN
    localparam accw_t SAT_HI = {1'b0, {(ACC_W-1){1'b1}}};
    localparam accw_t SAT_LO = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0]  wide_sum;
    logic                   clip;
    logic                   sat_q, sat_d;
    logic                   out_sat_q, out_sat_d;

    // One guard bit: overflow iff the two top bits disagree; the guard bit gives the true sign.
    always_comb begin
        wide_sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(sum_ext);
        clip     = wide_sum[ACC_W] != wide_sum[ACC_W-1];
        if (!clip) begin
            acc_next = wide_sum[ACC_W-1:0];
        end else if (wide_sum[ACC_W]) begin
            acc_next = SAT_LO;
        end else begin
            acc_next = SAT_HI;
        end
    end

    always_comb begin
        sat_d     = sat_q;
        out_sat_d = out_sat_q;
        if (en && s2_vld_q) begin
            if (s2_last_q) begin
                out_sat_d = sat_q | clip;
                sat_d     = 1'b0;
            end else begin
                sat_d     = sat_q | clip;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q     <= 1'b0;
            out_sat_q <= 1'b0;
        end else begin
            sat_q     <= sat_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign bus.out_sat = out_sat_q;
`else
    always_comb begin
        acc_next = acc_q + sum_ext;
    end

    assign bus.out_sat = 1'b0;
`endif

    always_comb begin
        en        = !out_vld_q || bus.out_ready;

        s1_vld_d  = s1_vld_q;
        s1_last_d = s1_last_q;
        s1_prod_d = s1_prod_q;
        s2_vld_d  = s2_vld_q;
        s2_last_d = s2_last_q;
        s2_sum_d  = s2_sum_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_vld_d = out_vld_q;
        out_res_d = out_res_q;
        out_len_d = out_len_q;

        if (en) begin
            s1_vld_d  = bus.in_valid;
            s1_last_d = bus.in_last;
            for (int i = 0; i < DEPTH; i++) begin
                s1_prod_d[i] = (2*DW)'($signed(bus.in_a[i])) * (2*DW)'($signed(bus.in_b[i]));
            end

            s2_vld_d  = s1_vld_q;
            s2_last_d = s1_last_q;
            s2_sum_d  = tree_sum;

            // A retiring result is replaced in the same cycle, so back-to-back vectors see no bubble.
            out_vld_d = s2_vld_q && s2_last_q;

            if (s2_vld_q) begin
                if (s2_last_q) begin
                    out_res_d = acc_next;
                    out_len_d = cnt_inc;
                    acc_d     = '0;
                    cnt_d     = '0;
                end else begin
                    acc_d     = acc_next;
                    cnt_d     = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                s1_prod_q[i] <= '0;
            end
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s2_sum_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            out_res_q <= '0;
            out_len_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            s1_prod_q <= s1_prod_d;
            s2_vld_q  <= s2_vld_d;
            s2_last_q <= s2_last_d;
            s2_sum_q  <= s2_sum_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_vld_q <= out_vld_d;
            out_res_q <= out_res_d;
            out_len_q <= out_len_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_vld_q;
    assign bus.out_res   = out_res_q;
    assign bus.out_len   = out_len_q;

endmodule

// File: tb/tb_dot_product_pipe.sv
// Directed bench for dot_product_pipe: a default instance (ACC_W=32) and a narrow one (ACC_W=18).
// Expected values are hand-computed; the ACC_W=18 result depends on DP_SAT_EN.
module tb_dot_product_pipe;

    typedef logic [31:0] vec_t;

    typedef struct {
        logic signed [31:0] res;
        logic [15:0]        len;
        logic               sat;
        int                 cyc;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    res_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dot_product_pipe_if #(.DW(8), .DEPTH(4), .ACC_W(32), .CNT_W(16)) bus ();
    dot_product_pipe_if #(.DW(8), .DEPTH(4), .ACC_W(18), .CNT_W(16)) bus2 ();

    dot_product_pipe #(.DW(8), .DEPTH(4), .ACC_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    dot_product_pipe #(.DW(8), .DEPTH(4), .ACC_W(18), .CNT_W(16)) dut_narrow (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    // Records every result handshake of the default instance with its cycle stamp.
    always @(negedge clk) begin : monitor
        res_t r;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            r.res = bus.out_res;
            r.len = bus.out_len;
            r.sat = bus.out_sat;
            r.cyc = cyc;
            q.push_back(r);
        end
    end

    function automatic vec_t rep(input int k);
        logic [7:0] kk;
        kk = k[7:0];
        return {kk, kk, kk, kk};
    endfunction

    task automatic send_beat(input vec_t a, input vec_t b, input logic last);
        bit done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_beat: in_ready=%b, required 1 within 50 cycles", bus.in_ready);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_queue(input int n);
        for (int i = 0; i < 40 && q.size() < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_last = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_res !== 32'sd0) begin errors++; $display("FAIL reset_out_res: got %0d want 0", bus.out_res); end
        checks++; if (bus.out_len !== 16'd0) begin errors++; $display("FAIL reset_out_len: got %0d want 0", bus.out_len); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat: got %b want 0", bus.out_sat); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int lat = 0;
        q.delete();
        bus.out_ready = 1'b1;
        send_beat(32'h04030201, 32'h08070605, 1'b1);
        idle();
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) lat = i;
        end
        checks++; if (lat != 3) begin errors++; $display("FAIL single_latency: got %0d cycles want 3", lat); end
        checks++; if (bus.out_res !== 32'sd70) begin errors++; $display("FAIL single_res: got %0d want 70", bus.out_res); end
        checks++; if (bus.out_len !== 16'd1) begin errors++; $display("FAIL single_len: got %0d want 1", bus.out_len); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL single_sat: got %b want 0", bus.out_sat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_multi_beat();
        q.delete();
        bus.out_ready = 1'b1;
        send_beat(32'h80808080, 32'h80808080, 1'b0);
        send_beat(32'h80808080, 32'h80808080, 1'b0);
        send_beat(32'h80808080, 32'h80808080, 1'b1);
        idle();
        wait_queue(1);
        checks++;
        if (q.size() != 1) begin
            errors++; $display("FAIL multi_count: got %0d results want 1", q.size());
        end else begin
            checks++; if (q[0].res !== 32'sd196608) begin errors++; $display("FAIL multi_res: got %0d want 196608", q[0].res); end
            checks++; if (q[0].len !== 16'd3) begin errors++; $display("FAIL multi_len: got %0d want 3", q[0].len); end
        end
    endtask

    task automatic test_stall();
        q.delete();
        bus.out_ready = 1'b0;
        for (int k = 2; k <= 4; k++) send_beat(32'h01010101, rep(k), 1'b1);
        bus.in_valid = 1'b1; bus.in_a = 32'h01010101; bus.in_b = rep(5); bus.in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_res !== 32'sd8) begin
                errors++; $display("FAIL stall_hold[%0d]: got valid=%b res=%0d want valid=1 res=8", i, bus.out_valid, bus.out_res);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send_beat(32'h01010101, rep(5), 1'b1);
        send_beat(32'h01010101, rep(6), 1'b1);
        idle();
        wait_queue(5);
        checks++;
        if (q.size() != 5) begin
            errors++; $display("FAIL stall_count: got %0d results want 5", q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (q[i].res !== 32'(8 + 4 * i) || q[i].len !== 16'd1) begin
                    errors++; $display("FAIL stall_res[%0d]: got res=%0d len=%0d want res=%0d len=1", i, q[i].res, q[i].len, 8 + 4 * i);
                end
                if (i > 0) begin
                    checks++; if (q[i].cyc - q[i-1].cyc != 1) begin
                        errors++; $display("FAIL stall_rate[%0d]: got gap %0d want 1", i, q[i].cyc - q[i-1].cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] kk;
        q.delete();
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            kk = k[7:0];
            send_beat({8'd1, 8'd1, 8'd1, kk}, 32'h01010101, 1'b1);
        end
        idle();
        wait_queue(6);
        checks++;
        if (q.size() != 6) begin
            errors++; $display("FAIL b2b_count: got %0d results want 6", q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (q[i].res !== 32'(i + 4) || q[i].len !== 16'd1 || q[i].sat !== 1'b0) begin
                    errors++; $display("FAIL b2b_res[%0d]: got res=%0d len=%0d sat=%b want res=%0d len=1 sat=0", i, q[i].res, q[i].len, q[i].sat, i + 4);
                end
                if (i > 0) begin
                    checks++; if (q[i].cyc - q[i-1].cyc != 1) begin
                        errors++; $display("FAIL b2b_rate[%0d]: got gap %0d want 1", i, q[i].cyc - q[i-1].cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_saturation();
        bit got = 1'b0;
`ifdef DP_SAT_EN
        logic signed [17:0] exp_res = 18'sd131071;
        logic               exp_sat = 1'b1;
`else
        logic signed [17:0] exp_res = -18'sd8160;
        logic               exp_sat = 1'b0;
`endif
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus2.in_valid = 1'b1; bus2.in_a = 32'h7f7f7f7f; bus2.in_b = 32'h7f7f7f7f; bus2.in_last = (i == 7);
            @(negedge clk);
            checks++; if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL sat_in_ready[%0d]: got %b want 1", i, bus2.in_ready); end
            @(posedge clk);
            #1;
        end
        bus2.in_valid = 1'b0; bus2.in_last = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus2.out_valid === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL sat_valid: got out_valid=0 want 1 within 10 cycles");
        end else begin
            checks++; if (bus2.out_res !== exp_res) begin errors++; $display("FAIL sat_res: got %0d want %0d", bus2.out_res, exp_res); end
            checks++; if (bus2.out_sat !== exp_sat) begin errors++; $display("FAIL sat_flag: got %b want %b", bus2.out_sat, exp_sat); end
            checks++; if (bus2.out_len !== 16'd8) begin errors++; $display("FAIL sat_len: got %0d want 8", bus2.out_len); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_vector();
        q.delete();
        bus.out_ready = 1'b1;
        send_beat(32'h01010101, 32'h01010101, 1'b0);
        send_beat(32'h01010101, 32'h01010101, 1'b0);
        idle();
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.out_res !== 32'sd0 || bus.out_len !== 16'd0 || bus.out_sat !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got valid=%b res=%0d len=%0d sat=%b want all 0", bus.out_valid, bus.out_res, bus.out_len, bus.out_sat);
        end
        checks++; if (bus2.out_res !== 18'sd0 || bus2.out_len !== 16'd0) begin
            errors++; $display("FAIL midreset_narrow: got res=%0d len=%0d want 0 0", bus2.out_res, bus2.out_len);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(32'h01010101, 32'h01010101, 1'b1);
        idle();
        wait_queue(1);
        checks++;
        if (q.size() != 1) begin
            errors++; $display("FAIL midreset_count: got %0d results want 1", q.size());
        end else begin
            checks++; if (q[0].res !== 32'sd4 || q[0].len !== 16'd1) begin
                errors++; $display("FAIL midreset_res: got res=%0d len=%0d want res=4 len=1", q[0].res, q[0].len);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_beat();
        test_stall();
        test_back_to_back();
        test_saturation();
        test_reset_mid_vector();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
